// File: rtl/y_div_a_sq_pkg.sv
// y_div_a_sq_pkg: shared widths, saturation value and FSM states for y_div_a_sq
package y_div_a_sq_pkg;
  localparam int YW = 12;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam logic [BW-1:0] SAT = '1;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SQR, S_DONE} state_t;
endpackage

// File: rtl/y_div_a_sq_udiv_restoring.sv
// udiv_restoring: YW-step restoring divider, one quotient bit per cycle, MSB first
module udiv_restoring #(
  parameter int YW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [YW-1:0] y,
  input  logic [AW-1:0] a,
  output logic          busy,
  output logic          last,
  output logic [YW-1:0] quot
);
  localparam int CW = $clog2(YW);
  logic [CW-1:0] cnt;
  logic [AW-1:0] d;
  logic [AW:0] rem, rs;
  logic ge;
  assign rs = {rem[AW-1:0], quot[YW-1]};
  assign ge = rs >= {1'b0, d};
  assign last = busy && cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      d    <= '0;
      rem  <= '0;
      quot <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= CW'(YW - 1);
      d    <= a;
      rem  <= '0;
      quot <= y;
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= ge ? rs - {1'b0, d} : rs;
      quot <= {quot[YW-2:0], ge};
      cnt  <= cnt - 1'b1;
      busy <= cnt != '0;
    end
  end
endmodule

// File: rtl/y_div_a_sq.sv
// y_div_a_sq: recovers floor(y/a)^2 via a restoring divide then a 4-step shift-add square
module y_div_a_sq
  import y_div_a_sq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [YW-1:0] y_in,
  input  logic [AW-1:0] a_in,
  input  logic          in_ready,
  output logic [BW-1:0] b_out,
  output logic          b_ready,
  output logic          err_out,
  output logic          busy_out
);
  state_t state;
  logic [3:0] cnt, qs;
  logic [BW-1:0] acc, add;
  logic [YW-1:0] div_q;
  logic err, ovf, div_busy, div_last;
  assign qs = div_q[3:0];
  assign ovf = |div_q[YW-1:4];
  assign add = qs[cnt[1:0]] ? BW'(qs) << cnt[1:0] : '0;
  assign busy_out = state != S_IDLE;
  udiv_restoring #(.YW(YW), .AW(AW)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .start(state == S_IDLE && in_ready && a_in != '0),
    .y    (y_in),
    .a    (a_in),
    .busy (div_busy),
    .last (div_last),
    .quot (div_q)
  );
  // Error paths pass through SQR for one cycle so the error decision sees the final quotient
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      err     <= 1'b0;
      b_out   <= '0;
      b_ready <= 1'b0;
      err_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_ready) begin
          b_ready <= 1'b0;
          err_out <= 1'b0;
          err     <= a_in == '0;
          acc     <= '0;
          cnt     <= 4'd3;
          state   <= a_in == '0 ? S_SQR : S_DIV;
        end
        S_DIV: if (div_last) state <= S_SQR;
        S_SQR: if (err || ovf) begin
          err   <= 1'b1;
          state <= S_DONE;
        end else begin
          acc   <= acc + add;
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? S_DONE : S_SQR;
        end
        S_DONE: begin
          b_out   <= err ? SAT : acc;
          err_out <= err;
          b_ready <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_y_div_a_sq.sv
// tb_y_div_a_sq: directed and randomized checks of y_div_a_sq against an arithmetic model
module tb_y_div_a_sq;
  logic clk = 0, rst_n = 0, in_ready = 0;
  logic [11:0] y_in = '0;
  logic [7:0] a_in = '0, b_out;
  logic b_ready, err_out, busy_out;
  int vectors = 0, miscompares = 0;

  y_div_a_sq dut (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .a_in(a_in), .in_ready(in_ready),
    .b_out(b_out), .b_ready(b_ready), .err_out(err_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int y, input int a, output int b, output int e, output int lat);
    int q;
    if (a == 0) begin b = 255; e = 1; lat = 2; return; end
    q = y / a;
    if (q > 15) begin b = 255; e = 1; lat = 14; end
    else begin b = q * q; e = 0; lat = 17; end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  // pulse: cycle after accept at which in_ready is raised for one cycle (0 = never)
  task automatic run(input int y, input int a, input int pulse);
    int b, e, lat, n;
    logic [7:0] prev;
    model(y, a, b, e, lat);
    wait_idle();
    prev = b_out;
    y_in = 12'(y); a_in = 8'(a); in_ready = 1;
    @(posedge clk); #1;
    in_ready = 0; y_in = 12'($urandom); a_in = 8'($urandom);
    chk("accept_busy", busy_out, 1);
    chk("accept_bready_low", b_ready, 0);
    chk("bout_held", b_out, prev);
    n = 0;
    do begin @(posedge clk); #1; n++; in_ready = (n == pulse); end while (!b_ready && n < 40);
    in_ready = 0;
    chk("latency", n, lat);
    chk("b_out", b_out, b);
    chk("err_out", err_out, e);
    @(posedge clk); #1;
    chk("bready_hold", b_ready, 1);
    chk("idle_after", busy_out, 0);
  endtask

  initial begin
    int a, q, y, b, s, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b_out", b_out, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_err", err_out, 0);
    chk("rst_busy", busy_out, 0);
    rst_n = 1;
    run(60, 5, 0);
    run(36, 12, 0);
    run(0, 7, 0);
    run(15, 1, 0);
    run(123, 0, 0);
    run(4095, 1, 0);
    run(60, 5, 5);
    run(60, 5, 14);
    run(60, 5, 16);
    // async reset in the middle of a divide
    wait_idle();
    y_in = 12'd60; a_in = 8'd5; in_ready = 1;
    @(posedge clk); #1; in_ready = 0;
    repeat (6) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_b_out", b_out, 0);
    chk("midrst_b_ready", b_ready, 0);
    chk("midrst_err", err_out, 0);
    chk("midrst_busy", busy_out, 0);
    @(negedge clk); rst_n = 1;
    run(60, 5, 0);
    // in_ready held high across two back-to-back requests
    wait_idle();
    y_in = 12'd36; a_in = 8'd12; in_ready = 1;
    @(posedge clk); #1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b_ready && n < 40);
    chk("b2b_lat1", n, 17);
    chk("b2b_b1", b_out, 9);
    y_in = 12'd15; a_in = 8'd1;
    @(posedge clk); #1;
    chk("b2b_bready_drop", b_ready, 0);
    chk("b2b_busy", busy_out, 1);
    in_ready = 0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!b_ready && n < 40);
    chk("b2b_lat2", n, 17);
    chk("b2b_b2", b_out, 225);
    chk("b2b_err2", err_out, 0);
    // random (y, a), biased toward quotients around the overflow boundary
    for (int i = 0; i < 30; i++) begin
      a = (i % 10 == 9) ? 0 : $urandom_range(1, 255);
      q = $urandom_range(0, 17);
      y = q * a + (a > 0 ? $urandom_range(0, a - 1) : $urandom_range(0, 4095));
      run(y > 4095 ? 4095 : y, a, 0);
    end
    // round trip from the forward block: y = a*floor(sqrt b)
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(1, 255);
      b = $urandom_range(0, 255);
      s = 0;
      while ((s + 1) * (s + 1) <= b) s++;
      run(a * s, a, 0);
      chk("roundtrip", b_out, s * s);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
